dmem_responder: RTL and testbench



---
 rtl/mem_if_pkg.sv | 27 ++
 rtl/bw_sram.sv | 36 +++
 rtl/dmem_responder.sv | 121 ++++++++++++
 tb/tb_dmem_responder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared definitions for memory-port responders
// Purpose: handshake state encoding, bus widths and the address-window check
//          used by data-memory, instruction-ROM and peripheral responders.
// Ports:   none (package).
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_e;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  // True when base <= addr < base + depth*4. Done in 33 bits so a window
  // ending at the top of the address map does not wrap to zero.
  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input int unsigned depth);
    logic [32:0] span;
    span = 33'(depth) << 2;
    return ({1'b0, addr} >= {1'b0, base}) &&
           ({1'b0, addr} <  ({1'b0, base} + span));
  endfunction

endpackage

// File: rtl/bw_sram.sv
// rtl/bw_sram.sv - synchronous byte-write single-port RAM
// Purpose: word-organised storage with per-byte write enables; read latency 1.
// Ports:   clk   - rising-edge clock
//          en    - port enable (read and write)
//          we    - byte write enables, bit i covers wdata[8i+7:8i]
//          addr  - word index
//          wdata - write word
//          rdata - registered read word (old contents on a write cycle)
module bw_sram
  import mem_if_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int          AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [BE_W-1:0]   we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (we[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with programmable wait states
// Purpose: slave end of the core data port; on-chip RAM with byte-enable
//          writes, WAIT_CYCLES extra cycles per access, one-cycle ready pulses.
// Ports:   clk, rstb (async active-low)
//          d_addr, d_wr_req, d_rd_req, d_be, d_wr_data - request from core
//          d_wr_ready, d_rd_ready - one-cycle completion pulses
//          d_rd_data - read word, non-zero only while d_rd_ready
//          d_err - out-of-range flag, pulses with the ready
module dmem_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic [31:0]       d_addr,
  input  logic              d_wr_req,
  output logic              d_wr_ready,
  input  logic              d_rd_req,
  output logic              d_rd_ready,
  input  logic [BE_W-1:0]   d_be,
  input  logic [WORD_W-1:0] d_wr_data,
  output logic [WORD_W-1:0] d_rd_data,
  output logic              d_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  mem_state_e        state, state_nxt;
  logic [3:0]        cnt;
  logic              op_wr_q;
  logic              rng_q;
  logic [AW-1:0]     idx_q;
  logic [BE_W-1:0]   be_q;
  logic [WORD_W-1:0] wdata_q;

  logic              req_any;
  logic              req_held;
  logic              rng_now;
  logic              sram_en;
  logic [BE_W-1:0]   sram_we;
  logic [AW-1:0]     sram_addr;
  logic [WORD_W-1:0] sram_rdata;

  assign req_any  = d_wr_req | d_rd_req;
  // Only the request that was accepted keeps the access alive.
  assign req_held = op_wr_q ? d_wr_req : d_rd_req;
  assign rng_now  = in_range(d_addr, BASE_ADDR, DEPTH);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (req_any) state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT: begin
        if (!req_held)      state_nxt = IDLE;
        else if (cnt == 0)  state_nxt = RESP;
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch and wait counter. A simultaneous write and read latches
  // as a write; the read is picked up on the next IDLE if still held.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt     <= '0;
      op_wr_q <= 1'b0;
      rng_q   <= 1'b0;
      idx_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && req_any) begin
      cnt     <= CNT_INIT;
      op_wr_q <= d_wr_req;
      rng_q   <= rng_now;
      idx_q   <= d_addr[AW+1:2];
      be_q    <= d_be;
      wdata_q <= d_wr_data;
    end else if (state == WAIT && cnt != 0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // The RAM reads every non-RESP cycle so the word is registered by the
  // time RESP arrives. With no wait states the read happens in IDLE, before
  // the index is latched, hence the live address there.
  assign sram_addr = (state == IDLE) ? d_addr[AW+1:2] : idx_q;
  assign sram_we   = (state == RESP && op_wr_q && rng_q) ? be_q : '0;
  assign sram_en   = (state != RESP) || (|sram_we);

  bw_sram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk   (clk),
    .en    (sram_en),
    .we    (sram_we),
    .addr  (sram_addr),
    .wdata (wdata_q),
    .rdata (sram_rdata)
  );

  // Outputs decode the registered state, so reset clears them at once.
  assign d_wr_ready = (state == RESP) &&  op_wr_q;
  assign d_rd_ready = (state == RESP) && !op_wr_q;
  assign d_err      = (state == RESP) && !rng_q;
  assign d_rd_data  = (state == RESP && !op_wr_q && rng_q) ? sram_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstb;
  logic [2:0]       wr, rd, wrdy, rrdy, err;
  logic [2:0][31:0] addr, wd, rdat;
  logic [2:0][3:0]  be;

  int n_cmp = 0;
  int n_bad = 0;
  int lat_of[3] = '{1, 4, 5};

  // Index 0: no wait states, 1: three, 2: four. All 16 words at 0x2000.
  dmem_responder #(.DEPTH(16), .BASE_ADDR(32'h2000), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rstb(rstb), .d_addr(addr[0]), .d_wr_req(wr[0]), .d_wr_ready(wrdy[0]),
    .d_rd_req(rd[0]), .d_rd_ready(rrdy[0]), .d_be(be[0]), .d_wr_data(wd[0]),
    .d_rd_data(rdat[0]), .d_err(err[0]));
  dmem_responder #(.DEPTH(16), .BASE_ADDR(32'h2000), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rstb(rstb), .d_addr(addr[1]), .d_wr_req(wr[1]), .d_wr_ready(wrdy[1]),
    .d_rd_req(rd[1]), .d_rd_ready(rrdy[1]), .d_be(be[1]), .d_wr_data(wd[1]),
    .d_rd_data(rdat[1]), .d_err(err[1]));
  dmem_responder #(.DEPTH(16), .BASE_ADDR(32'h2000), .WAIT_CYCLES(4)) u_w4 (
    .clk(clk), .rstb(rstb), .d_addr(addr[2]), .d_wr_req(wr[2]), .d_wr_ready(wrdy[2]),
    .d_rd_req(rd[2]), .d_rd_ready(rrdy[2]), .d_be(be[2]), .d_wr_data(wd[2]),
    .d_rd_data(rdat[2]), .d_err(err[2]));

  typedef struct {
    bit          w;
    bit          r;
    logic [31:0] a;
    logic [3:0]  b;
    logic [31:0] d;
    bit          e;
    logic [31:0] x;
  } vec_t;

  vec_t tv[13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic acc(input int k, input bit w, input bit r, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] d, input bit e,
                     input logic [31:0] x, input string nm);
    int n;
    bit got;
    bit got_wr, got_rr, got_err;
    logic [31:0] got_rd;
    n = 0; got = 0; got_wr = 0; got_rr = 0; got_err = 0; got_rd = '0;
    addr[k] = a; be[k] = b; wd[k] = d; wr[k] = w; rd[k] = r;
    while (!got && n < 40) begin
      step();
      n++;
      if (wrdy[k] || rrdy[k]) begin
        got = 1; got_wr = wrdy[k]; got_rr = rrdy[k]; got_err = err[k]; got_rd = rdat[k];
      end
    end
    wr[k] = 1'b0; rd[k] = 1'b0;
    chk({nm, " ready seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({nm, " latency"}, 32'(n), 32'(lat_of[k]));
      chk({nm, " wr_ready"}, 32'(got_wr), 32'(w));
      chk({nm, " rd_ready"}, 32'(got_rr), 32'(r && !w));
      chk({nm, " err"}, 32'(got_err), 32'(e));
      if (r && !w) chk({nm, " rd_data"}, got_rd, x);
    end
    step();
    chk({nm, " after flags"}, {29'd0, wrdy[k], rrdy[k], err[k]}, 32'd0);
    chk({nm, " after rd_data"}, rdat[k], 32'd0);
  endtask

  function automatic logic [31:0] final_word(input int i);
    if (i == 2) return 32'hDEAD_BEEF;
    if (i == 3) return 32'h11BB_33DD;
    return 32'hA000_0000 + 32'(i);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rstb = 1'b0; wr = '0; rd = '0; addr = '0; wd = '0; be = '0;
    #12;
    chk("reset ready/err", {26'd0, wrdy, rrdy}, 32'd0);
    chk("reset err", {29'd0, err}, 32'd0);
    chk("reset rd_data w0", rdat[0], 32'd0);
    chk("reset rd_data w4", rdat[2], 32'd0);
    rstb = 1'b1;

    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 16; i++)
        acc(k, 1, 0, 32'(32'h2000 + 4 * i), 4'hF, 32'hA000_0000 + 32'(i), 0, 32'd0,
            $sformatf("pre%0d_%0d", k, i));

    tv[0]  = '{1, 0, 32'h2008, 4'hF, 32'hDEAD_BEEF, 0, 32'h0};
    tv[1]  = '{0, 1, 32'h2008, 4'h0, 32'h0,         0, 32'hDEAD_BEEF};
    tv[2]  = '{1, 0, 32'h200C, 4'hF, 32'h1122_3344, 0, 32'h0};
    tv[3]  = '{1, 0, 32'h200C, 4'h5, 32'hAABB_CCDD, 0, 32'h0};
    tv[4]  = '{0, 1, 32'h200C, 4'h0, 32'h0,         0, 32'h11BB_33DD};
    tv[5]  = '{1, 0, 32'h200C, 4'h0, 32'hFFFF_FFFF, 0, 32'h0};
    tv[6]  = '{0, 1, 32'h200C, 4'h0, 32'h0,         0, 32'h11BB_33DD};
    tv[7]  = '{0, 1, 32'h200B, 4'h0, 32'h0,         0, 32'hDEAD_BEEF};
    tv[8]  = '{1, 0, 32'h1FFC, 4'hF, 32'h1234_5678, 1, 32'h0};
    tv[9]  = '{0, 1, 32'h2040, 4'h0, 32'h0,         1, 32'h0};
    tv[10] = '{1, 0, 32'h2040, 4'hF, 32'h8765_4321, 1, 32'h0};
    tv[11] = '{0, 1, 32'h203C, 4'h0, 32'h0,         0, 32'hA000_000F};
    tv[12] = '{0, 1, 32'h2000, 4'h0, 32'h0,         0, 32'hA000_0000};
    for (int i = 0; i < 13; i++)
      acc(0, tv[i].w, tv[i].r, tv[i].a, tv[i].b, tv[i].d, tv[i].e, tv[i].x,
          $sformatf("vec%0d", i));

    for (int i = 0; i < 16; i++)
      acc(0, 0, 1, 32'(32'h2000 + 4 * i), 4'h0, 32'h0, 0, final_word(i),
          $sformatf("sweep%0d", i));

    // Write and read together: write wins, read follows after one IDLE.
    addr[0] = 32'h2010; wd[0] = 32'h55AA_55AA; be[0] = 4'hF; wr[0] = 1'b1; rd[0] = 1'b1;
    step();
    chk("both wr_ready", 32'(wrdy[0]), 32'd1);
    chk("both rd_ready", 32'(rrdy[0]), 32'd0);
    wr[0] = 1'b0;
    step();
    chk("both gap", {30'd0, wrdy[0], rrdy[0]}, 32'd0);
    step();
    chk("both rd second", 32'(rrdy[0]), 32'd1);
    chk("both rd data", rdat[0], 32'h55AA_55AA);
    rd[0] = 1'b0;
    step();

    // Three wait states, request held across two accesses; address moved
    // mid-WAIT is ignored by the first access and used by the second.
    addr[1] = 32'h2008; rd[1] = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      chk($sformatf("w3 rd_ready c%0d", c), 32'(rrdy[1]), 32'(c == 4 || c == 9));
      if (c == 4) chk("w3 first data", rdat[1], 32'hA000_0002);
      if (c == 9) chk("w3 second data", rdat[1], 32'hA000_0005);
      if (c == 2) addr[1] = 32'h2014;
    end
    rd[1] = 1'b0;
    step();

    // Four wait states: read dropped while waiting never completes.
    addr[2] = 32'h2004; rd[2] = 1'b1;
    step();
    step();
    rd[2] = 1'b0;
    for (int c = 3; c <= 10; c++) begin
      step();
      chk($sformatf("abort no ready c%0d", c), {30'd0, wrdy[2], rrdy[2]}, 32'd0);
    end
    acc(2, 0, 1, 32'h2004, 4'h0, 32'h0, 0, 32'hA000_0001, "after abort");

    // Reset during a write's WAIT: nothing is committed.
    addr[2] = 32'h2004; wd[2] = 32'h2222_2222; be[2] = 4'hF; wr[2] = 1'b1;
    step();
    step();
    #2 rstb = 1'b0;
    #1;
    chk("rst wait flags", {29'd0, wrdy[2], rrdy[2], err[2]}, 32'd0);
    wr[2] = 1'b0;
    step();
    rstb = 1'b1;
    acc(2, 0, 1, 32'h2004, 4'h0, 32'h0, 0, 32'hA000_0001, "after rst");

    // Reset during RESP clears ready and data without waiting for a clock.
    addr[0] = 32'h2008; rd[0] = 1'b1;
    step();
    chk("resp rd_ready", 32'(rrdy[0]), 32'd1);
    chk("resp rd_data", rdat[0], 32'hDEAD_BEEF);
    #2 rstb = 1'b0;
    #1;
    chk("async rd_ready", 32'(rrdy[0]), 32'd0);
    chk("async rd_data", rdat[0], 32'd0);
    rd[0] = 1'b0;
    step();
    rstb = 1'b1;
    acc(0, 0, 1, 32'h2008, 4'h0, 32'h0, 0, 32'hDEAD_BEEF, "ram kept");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
